// File: rtl/floor_call_memory.sv
// floor_call_memory: shift-register queue of pending elevator floor calls.
// Entry 0 is the head; valid entries are packed into 0..memCount-1.
// Each cycle a pop (head removal) is applied first, and any insert then
// operates on the post-pop contents. Both commit on the same clock edge.
module floor_call_memory #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write_En,
   input  logic [2:0] nextMemoryFloor,
   input  logic [1:0] BeginEndMemory_Flag,
   input  logic       floorReached,
   output logic [1:0] pos0Mem,
   output logic [2:0] memCount,
   output logic       memEmpty,
   output logic       memFull,
   output logic       dropCall
);

   logic [1:0] mem_q   [DEPTH];
   logic [1:0] mem_d   [DEPTH];
   logic [1:0] pop_mem [DEPTH];
   logic [2:0] count_q, count_d, pop_cnt;
   logic       empty_q, empty_d;
   logic       full_q, full_d;
   logic       drop_q, drop_d;
   logic       dup;
   logic [1:0] new_floor;

   assign new_floor = nextMemoryFloor[1:0];

   // Next-state queue contents: pop phase, then insert phase on the result.
   always_comb begin
      pop_mem = mem_q;
      pop_cnt = count_q;
      if (floorReached && (count_q != '0)) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            pop_mem[i] = mem_q[i + 1];
         end
         pop_mem[DEPTH - 1] = '0;
         pop_cnt = count_q - 3'd1;
      end

      // Slots at or above the count hold 0, so only compare valid ones.
      dup = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((3'(i) < pop_cnt) && (pop_mem[i] == new_floor)) begin
            dup = 1'b1;
         end
      end

      mem_d   = pop_mem;
      count_d = pop_cnt;
      drop_d  = 1'b0;

      if (write_En && BeginEndMemory_Flag[1]) begin
         if (nextMemoryFloor > 3'd3) begin
            drop_d = 1'b1;
         end else if (dup) begin
            drop_d = 1'b0;
         end else if (pop_cnt == 3'(DEPTH)) begin
            drop_d = 1'b1;
         end else if (BeginEndMemory_Flag[0]) begin
            // Whole-array shift is safe: the top slot is empty when not full.
            for (int unsigned i = 1; i < DEPTH; i++) begin
               mem_d[i] = pop_mem[i - 1];
            end
            mem_d[0] = new_floor;
            count_d  = pop_cnt + 3'd1;
         end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (3'(i) == pop_cnt) begin
                  mem_d[i] = new_floor;
               end
            end
            count_d = pop_cnt + 3'd1;
         end
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == 3'(DEPTH));
   end

   // State and registered status flags; synchronous reset has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         drop_q  <= drop_d;
      end
   end

   assign pos0Mem  = mem_q[0];
   assign memCount = count_q;
   assign memEmpty = empty_q;
   assign memFull  = full_q;
   assign dropCall = drop_q;

endmodule
